// File: rtl/eq_match_tracker.sv
`default_nettype none
// ============================================================================
// Module      : eq_match_tracker
// Description : Sequential consumer for the equality comparator stage.
//               Operand pairs (a,b) arrive on a valid/ready stream. Each
//               accepted pair produces a registered equal flag one cycle
//               later. A run FSM raises `locked` after RUN_LEN consecutive
//               equal pairs. Saturating totals count matches and mismatches.
//
// Parameters  : WIDTH   - operand width of a and b
//               RUN_LEN - consecutive equal pairs needed to lock (>=1)
//               CNT_W   - width of the saturating total counters
//
// Ports       : clk, rst (async, active-high), clear (sync clear of FSM,
//               run and totals), in_valid/in_ready/a/b (input stream),
//               out_valid/out_ready/out_eq (result stream), locked,
//               run_cnt, match_cnt, mismatch_cnt (status).
//
// Build option: STICKY_LOCK_EN - when defined, a mismatch in LOCKED keeps
//               the FSM locked; only clear or rst leaves LOCKED.
//
// Revision    : 1.0 - initial release
// ============================================================================
module eq_match_tracker #(
    parameter int WIDTH   = 2,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_eq,
    output logic                       locked,
    output logic [$clog2(RUN_LEN+1)-1:0] run_cnt,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [CNT_W-1:0]           mismatch_cnt
);

    localparam int              RUN_W   = $clog2(RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic               valid_q,    valid_d;
    logic               eq_q,       eq_d;
    logic               locked_q,   locked_d;
    logic [RUN_W-1:0]   run_q,      run_d;
    logic [CNT_W-1:0]   match_q,    match_d;
    logic [CNT_W-1:0]   mismatch_q, mismatch_d;

    logic               accept;
    logic               pair_eq;

    // A stalled result blocks intake so it can never be overwritten.
    assign in_ready = !clear && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pair_eq  = (a == b);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        eq_d       = eq_q;
        run_d      = run_q;
        match_d    = match_q;
        mismatch_d = mismatch_q;

        // Result register: load on accept, drain when consumed, else hold.
        if (accept) begin
            valid_d = 1'b1;
            eq_d    = pair_eq;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (clear) begin
            state_d    = ST_IDLE;
            run_d      = '0;
            match_d    = '0;
            mismatch_d = '0;
        end else if (accept) begin
            if (pair_eq) begin
                if (match_q != CNT_MAX) match_d = match_q + CNT_W'(1);
            end else begin
                if (mismatch_q != CNT_MAX) mismatch_d = mismatch_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (pair_eq) begin
                        run_d   = RUN_W'(1);
                        state_d = (RUN_LEN == 1) ? ST_LOCKED : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pair_eq) begin
                        run_d   = run_q + RUN_W'(1);
                        if (run_q + RUN_W'(1) >= RUN_MAX) begin
                            run_d   = RUN_MAX;
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        run_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    run_d = RUN_MAX;
`ifdef STICKY_LOCK_EN
                    state_d = ST_LOCKED;
`else
                    if (!pair_eq) begin
                        run_d   = '0;
                        state_d = ST_IDLE;
                    end
`endif
                end
                default: begin
                    run_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE && state_q != ST_RUN && state_q != ST_LOCKED) begin
            // Corrupted encoding: fall back to a clean IDLE without waiting for a pair.
            run_d   = '0;
            state_d = ST_IDLE;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            eq_q       <= 1'b0;
            locked_q   <= 1'b0;
            run_q      <= '0;
            match_q    <= '0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            eq_q       <= eq_d;
            locked_q   <= locked_d;
            run_q      <= run_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_eq       = eq_q;
    assign locked       = locked_q;
    assign run_cnt      = run_q;
    assign match_cnt    = match_q;
    assign mismatch_cnt = mismatch_q;

endmodule
`default_nettype wire
